// File: rtl/pool_pkg.sv
// Shared types for the pooling datapath: pooled value width, column count, row container.
package pool_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int COL        = 32;

  typedef logic [DATA_WIDTH-1:0] pix_t;
  typedef pix_t row_t [COL];
endpackage

// File: rtl/pool_row_collector_if.sv
// Row output handshake between the row collector (master) and the output-memory writer (slave).
interface pool_row_collector_if #(
  parameter int NUM_ROWS = 16,
  parameter int ADDR_W   = $clog2(NUM_ROWS)
);
  import pool_pkg::*;

  logic              out_valid;
  logic              out_ready;
  row_t              out_data;
  logic [ADDR_W-1:0] row_addr;

  modport master (output out_valid, output out_data, output row_addr, input out_ready);
  modport slave  (input out_valid, input out_data, input row_addr, output out_ready);
endinterface

// File: rtl/pool_row_bank.sv
// One row bank: per-column value registers and filled bits; a column write wins over clear-all.
module pool_row_bank
  import pool_pkg::*;
(
  input  logic           clk,
  input  logic           nrst,
  input  logic           clr,
  input  logic [COL-1:0] wr_en,
  input  row_t           wr_data,
  output row_t           rd_data,
  output logic [COL-1:0] filled
);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      filled <= '0;
      for (int j = 0; j < COL; j++) rd_data[j] <= '0;
    end else begin
      for (int j = 0; j < COL; j++) begin
        if (wr_en[j]) begin
          filled[j]  <= 1'b1;
          rd_data[j] <= wr_data[j];
        end else if (clr) begin
          filled[j]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/pool_row_collector.sv
// Collects staggered per-column pooling results into double-buffered rows and hands them to the
// output writer with a row address; reports dropped results and end of layer.
module pool_row_collector
  import pool_pkg::*;
#(
  parameter int NUM_ROWS = 16,
  parameter int ADDR_W   = $clog2(NUM_ROWS)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [COL-1:0]        pool_done,
  input  row_t                  pool_out,
  pool_row_collector_if.master  out_if,
  output logic                  layer_done,
  output logic                  ovf_err
);

  logic [COL-1:0]    wb;
  logic              rd_bank;
  logic [ADDR_W-1:0] row_addr_q;
  logic [COL-1:0]    filled0, filled1;
  logic [COL-1:0]    wr_en0, wr_en1;
  logic [COL-1:0]    tgt_full, cap, drop;
  logic              clr0, clr1, drain;
  row_t              data0, data1;

  assign drain = out_if.out_valid & out_if.out_ready;
  assign clr0  = start | (drain & ~rd_bank);
  assign clr1  = start | (drain &  rd_bank);

  // Fullness is judged after this cycle's drain, so a bank freed now can be refilled now.
  always_comb begin
    for (int j = 0; j < COL; j++) begin
      tgt_full[j] = wb[j] ? (filled1[j] & ~clr1) : (filled0[j] & ~clr0);
    end
  end

  assign cap    = pool_done & ~tgt_full & {COL{~start}};
  assign drop   = pool_done &  tgt_full & {COL{~start}};
  assign wr_en0 = cap & ~wb;
  assign wr_en1 = cap &  wb;

  pool_row_bank u_bank0 (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (clr0),
    .wr_en   (wr_en0),
    .wr_data (pool_out),
    .rd_data (data0),
    .filled  (filled0)
  );

  pool_row_bank u_bank1 (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (clr1),
    .wr_en   (wr_en1),
    .wr_data (pool_out),
    .rd_data (data1),
    .filled  (filled1)
  );

  assign out_if.out_valid = rd_bank ? (&filled1) : (&filled0);
  assign out_if.row_addr  = row_addr_q;

  always_comb begin
    for (int j = 0; j < COL; j++) begin
      out_if.out_data[j] = rd_bank ? data1[j] : data0[j];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wb         <= '0;
      rd_bank    <= 1'b0;
      row_addr_q <= '0;
      layer_done <= 1'b0;
      ovf_err    <= 1'b0;
    end else if (start) begin
      wb         <= '0;
      rd_bank    <= 1'b0;
      row_addr_q <= '0;
      layer_done <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      wb         <= wb ^ cap;
      layer_done <= drain && (row_addr_q == ADDR_W'(NUM_ROWS - 1));
      if (|drop) ovf_err <= 1'b1;
      if (drain) begin
        rd_bank    <= ~rd_bank;
        row_addr_q <= (row_addr_q == ADDR_W'(NUM_ROWS - 1)) ? '0 : row_addr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pool_row_collector.sv
// Directed bench for pool_row_collector with NUM_ROWS=4: staggered row streams, backpressure,
// overlap, address wrap, pseudo-random ready, and start/reset in the middle of a row.
module tb_pool_row_collector;
  import pool_pkg::*;

  localparam int NR = 4;
  localparam int AW = $clog2(NR);
  typedef logic [COL*DATA_WIDTH-1:0] flat_t;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic           start = 1'b0;
  logic [COL-1:0] pool_done = '0;
  row_t           pool_out;
  logic           layer_done, ovf_err;

  pool_row_collector_if #(.NUM_ROWS(NR)) out_if ();

  pool_row_collector #(.NUM_ROWS(NR)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .pool_done  (pool_done),
    .pool_out   (pool_out),
    .out_if     (out_if),
    .layer_done (layer_done),
    .ovf_err    (ovf_err)
  );

  int n_chk = 0;
  int n_err = 0;

  flat_t          q_data[$];
  logic [AW-1:0]  q_addr[$];
  int             q_cyc[$];
  int             ld_cnt = 0;
  int             stall_viol = 0;
  int             cyc = 0;
  logic [15:0]    lfsr = 16'hACE1;

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  function automatic pix_t val(input int r, input int j);
    return pix_t'((r + 1) * 256 + j);
  endfunction

  function automatic flat_t exp_row(input int r);
    flat_t f;
    for (int j = 0; j < COL; j++) f[j*DATA_WIDTH +: DATA_WIDTH] = val(r, j);
    return f;
  endfunction

  function automatic flat_t flatten(input row_t rw);
    flat_t f;
    for (int j = 0; j < COL; j++) f[j*DATA_WIDTH +: DATA_WIDTH] = rw[j];
    return f;
  endfunction

  // Passive monitor: records transfers, layer_done pulses and any change under stall.
  initial begin
    flat_t cur, prev_data;
    logic [AW-1:0] prev_addr;
    logic prev_stall;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      cur = flatten(out_if.out_data);
      if (prev_stall && (!out_if.out_valid || cur !== prev_data || out_if.row_addr !== prev_addr))
        stall_viol++;
      if (out_if.out_valid && out_if.out_ready) begin
        q_data.push_back(cur);
        q_addr.push_back(out_if.row_addr);
        q_cyc.push_back(cyc);
      end
      if (layer_done) ld_cnt++;
      prev_stall = out_if.out_valid && !out_if.out_ready;
      prev_data  = cur;
      prev_addr  = out_if.row_addr;
      cyc++;
    end
  end

  task automatic clear_mon();
    q_data.delete();
    q_addr.delete();
    q_cyc.delete();
    ld_cnt = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    pool_done = '0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) begin
      @(posedge clk); #1;
      pool_done = '0;
      out_if.out_ready = rdy;
    end
  endtask

  // Row r column j is strobed in cycle r*gap + j; rmode 0/1 fixed ready, 2 pseudo-random.
  task automatic drive_rows(input int nrows, input int gap, input int ncols, input int rmode,
                            input int tail);
    int total, j;
    total = (nrows - 1) * gap + COL + tail;
    for (int c = 0; c < total; c++) begin
      @(posedge clk); #1;
      pool_done = '0;
      for (int r = 0; r < nrows; r++) begin
        j = c - r * gap;
        if (j >= 0 && j < ncols) begin
          pool_done[j] = 1'b1;
          pool_out[j]  = val(r, j);
        end
      end
      if (rmode == 2) begin
        out_if.out_ready = lfsr[0];
        lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end else begin
        out_if.out_ready = (rmode == 1);
      end
    end
    @(posedge clk); #1;
    pool_done = '0;
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if (out_if.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_if.out_valid); end
    n_chk++; if (flatten(out_if.out_data) !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", flatten(out_if.out_data)); end
    n_chk++; if (out_if.row_addr !== '0) begin n_err++; $display("FAIL reset_addr got=%0d exp=0", out_if.row_addr); end
    n_chk++; if (layer_done !== 1'b0) begin n_err++; $display("FAIL reset_layer_done got=%b exp=0", layer_done); end
    n_chk++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf_err); end
    @(posedge clk); #1;
    nrst = 1'b1;
  endtask

  task automatic test_single_row();
    pulse_start();
    clear_mon();
    for (int c = 0; c <= COL; c++) begin
      @(posedge clk); #1;
      pool_done = '0;
      out_if.out_ready = 1'b0;
      if (c < COL) begin
        pool_done[c] = 1'b1;
        pool_out[c]  = val(0, c);
      end
      @(negedge clk);
      if (c == COL - 1) begin
        n_chk++; if (out_if.out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got=%b exp=0", out_if.out_valid); end
      end
      if (c == COL) begin
        n_chk++; if (out_if.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", out_if.out_valid); end
        n_chk++; if (flatten(out_if.out_data) !== exp_row(0)) begin n_err++; $display("FAIL single_data got=%h exp=%h", flatten(out_if.out_data), exp_row(0)); end
        n_chk++; if (out_if.row_addr !== 2'd0) begin n_err++; $display("FAIL single_addr got=%0d exp=0", out_if.row_addr); end
      end
    end
    @(posedge clk); #1;
    out_if.out_ready = 1'b1;
    @(posedge clk); #1;
    out_if.out_ready = 1'b0;
    @(negedge clk);
    n_chk++; if (q_data.size() !== 1) begin n_err++; $display("FAIL single_xfers got=%0d exp=1", q_data.size()); end
    n_chk++; if (out_if.out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_after got=%b exp=0", out_if.out_valid); end
    n_chk++; if (out_if.row_addr !== 2'd1) begin n_err++; $display("FAIL single_addr_next got=%0d exp=1", out_if.row_addr); end
  endtask

  task automatic test_backpressure();
    pulse_start();
    clear_mon();
    drive_rows(3, COL, COL, 0, 4);
    @(negedge clk);
    n_chk++; if (out_if.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got=%b exp=1", out_if.out_valid); end
    n_chk++; if (flatten(out_if.out_data) !== exp_row(0)) begin n_err++; $display("FAIL bp_held_data got=%h exp=%h", flatten(out_if.out_data), exp_row(0)); end
    n_chk++; if (out_if.row_addr !== 2'd0) begin n_err++; $display("FAIL bp_held_addr got=%0d exp=0", out_if.row_addr); end
    n_chk++; if (ovf_err !== 1'b1) begin n_err++; $display("FAIL bp_ovf got=%b exp=1", ovf_err); end
    n_chk++; if (q_data.size() !== 0) begin n_err++; $display("FAIL bp_no_xfer got=%0d exp=0", q_data.size()); end
    idle(4, 1'b1);
    @(negedge clk);
    n_chk++; if (q_data.size() !== 2) begin n_err++; $display("FAIL bp_drain_count got=%0d exp=2", q_data.size()); end
    for (int k = 0; k < 2; k++) begin
      if (q_data.size() > k) begin
        n_chk++; if (q_data[k] !== exp_row(k)) begin n_err++; $display("FAIL bp_row%0d_data got=%h exp=%h", k, q_data[k], exp_row(k)); end
        n_chk++; if (q_addr[k] !== AW'(k)) begin n_err++; $display("FAIL bp_row%0d_addr got=%0d exp=%0d", k, q_addr[k], k); end
      end
    end
    if (q_cyc.size() > 1) begin
      n_chk++; if (q_cyc[1] - q_cyc[0] !== 1) begin n_err++; $display("FAIL bp_consecutive got=%0d exp=1", q_cyc[1] - q_cyc[0]); end
    end
    n_chk++; if (out_if.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got=%b exp=0", out_if.out_valid); end
    pulse_start();
    @(negedge clk);
    n_chk++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL bp_ovf_cleared got=%b exp=0", ovf_err); end
  endtask

  task automatic check_stream(input string name, input int nrows);
    n_chk++; if (q_data.size() !== nrows) begin n_err++; $display("FAIL %s_count got=%0d exp=%0d", name, q_data.size(), nrows); end
    for (int k = 0; k < nrows; k++) begin
      if (q_data.size() > k) begin
        n_chk++; if (q_data[k] !== exp_row(k)) begin n_err++; $display("FAIL %s_row%0d_data got=%h exp=%h", name, k, q_data[k], exp_row(k)); end
        n_chk++; if (q_addr[k] !== AW'(k % NR)) begin n_err++; $display("FAIL %s_row%0d_addr got=%0d exp=%0d", name, k, q_addr[k], k % NR); end
      end
    end
    n_chk++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL %s_ovf got=%b exp=0", name, ovf_err); end
  endtask

  task automatic test_overlap();
    pulse_start();
    clear_mon();
    drive_rows(2, COL - 1, COL, 1, 6);
    @(negedge clk);
    check_stream("overlap", 2);
  endtask

  task automatic test_back_to_back();
    pulse_start();
    clear_mon();
    drive_rows(2, 1, COL, 1, 6);
    @(negedge clk);
    check_stream("b2b", 2);
    if (q_cyc.size() > 1) begin
      n_chk++; if (q_cyc[1] - q_cyc[0] !== 1) begin n_err++; $display("FAIL b2b_consecutive got=%0d exp=1", q_cyc[1] - q_cyc[0]); end
    end
  endtask

  task automatic test_wrap();
    pulse_start();
    clear_mon();
    drive_rows(5, COL, COL, 1, 6);
    @(negedge clk);
    check_stream("wrap", 5);
    n_chk++; if (ld_cnt !== 1) begin n_err++; $display("FAIL wrap_layer_done got=%0d exp=1", ld_cnt); end
  endtask

  task automatic test_random_ready();
    int sv0;
    pulse_start();
    clear_mon();
    sv0 = stall_viol;
    drive_rows(8, COL, COL, 2, 40);
    idle(4, 1'b1);
    @(negedge clk);
    check_stream("rand", 8);
    n_chk++; if (ld_cnt !== 2) begin n_err++; $display("FAIL rand_layer_done got=%0d exp=2", ld_cnt); end
    n_chk++; if (stall_viol !== sv0) begin n_err++; $display("FAIL rand_stall_stable got=%0d exp=%0d", stall_viol, sv0); end
  endtask

  task automatic test_abort(input logic use_reset);
    string nm;
    nm = use_reset ? "rst" : "start";
    pulse_start();
    drive_rows(1, COL, COL, 1, 4);
    clear_mon();
    drive_rows(1, COL, 10, 1, 0);
    if (use_reset) begin
      @(negedge clk);
      nrst = 1'b0;
      #2;
      @(posedge clk); #1;
      nrst = 1'b1;
    end else begin
      pulse_start();
    end
    idle(COL + 4, 1'b1);
    @(negedge clk);
    n_chk++; if (q_data.size() !== 0) begin n_err++; $display("FAIL %s_no_row got=%0d exp=0", nm, q_data.size()); end
    n_chk++; if (out_if.out_valid !== 1'b0) begin n_err++; $display("FAIL %s_valid got=%b exp=0", nm, out_if.out_valid); end
    n_chk++; if (out_if.row_addr !== 2'd0) begin n_err++; $display("FAIL %s_addr got=%0d exp=0", nm, out_if.row_addr); end
    n_chk++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL %s_ovf got=%b exp=0", nm, ovf_err); end
    drive_rows(1, COL, COL, 1, 4);
    @(negedge clk);
    check_stream({nm, "_after"}, 1);
  endtask

  initial begin
    out_if.out_ready = 1'b0;
    for (int j = 0; j < COL; j++) pool_out[j] = '0;
    test_reset();
    test_single_row();
    test_backpressure();
    test_overlap();
    test_back_to_back();
    test_wrap();
    test_random_ready();
    test_abort(1'b0);
    test_abort(1'b1);
    n_chk++; if (stall_viol !== 0) begin n_err++; $display("FAIL stall_stability got=%0d exp=0", stall_viol); end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
